// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the system-clock-synchronous SPI slave:
//   - state_t     : controller states (IDLE, LOAD, SHIFT)
//   - CPOL_* / CPHA_* : encodings of the SPI mode parameters
//   - bit_index() : maps the running bit count onto a word bit position
//                   according to the configured bit order
// -----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // SCLK idle level
  localparam bit CPOL_IDLE_LOW  = 1'b0;
  localparam bit CPOL_IDLE_HIGH = 1'b1;

  // Which SCLK edge samples data
  localparam bit CPHA_SAMPLE_LEADING  = 1'b0;
  localparam bit CPHA_SAMPLE_TRAILING = 1'b1;

  // Bit position within a word of the count-th transferred bit.
  function automatic int unsigned bit_index(input int unsigned count,
                                            input bit          lsb_first,
                                            input int unsigned width);
    return lsb_first ? count : (width - 1 - count);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Multi-flop synchroniser for an asynchronous pin plus rise/fall detection of
// the synchronised level against its value one clk earlier.
// Ports:
//   clk      in  : system clock
//   reset_n  in  : asynchronous active-low reset
//   i_async  in  : asynchronous pin
//   o_sync   out : synchronised level (SYNC_STAGES clk latency)
//   o_rise   out : one-cycle pulse on a synchronised 0->1 transition
//   o_fall   out : one-cycle pulse on a synchronised 1->0 transition
// -----------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Reset to the pin's idle level so that leaving reset never fakes an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = o_sync & ~r_prev;
  assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/spi_slave_core.sv
// -----------------------------------------------------------------------------
// spi_slave_core
// SPI slave running entirely in the clk domain. SCLK, CS and MOSI are
// oversampled through synchronisers; SCLK edges become drive/sample events
// according to CPOL/CPHA. Words of DATA_WIDTH bits are exchanged back to back
// while CS stays low. The core supplies TX words through a one-deep holding
// register (tx_valid/tx_ready) and receives RX words with an rx_valid pulse.
// Ports:
//   clk, reset_n        : system clock, asynchronous active-low reset
//   SCLK, CS, MOSI      : SPI pins (asynchronous, CS active-low)
//   MISO, MISO_oe       : registered slave data and output enable
//   tx_data/valid/ready : holding register write handshake
//   rx_data, rx_valid   : last complete word, one-cycle completion pulse
//   busy                : synchronised CS low
//   underrun, abort     : sticky status, cleared by clr_status
// -----------------------------------------------------------------------------
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter bit LSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  SCLK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISO_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  underrun,
  output logic                  abort,
  input  logic                  clr_status
);

  localparam int CNT_W     = $clog2(DATA_WIDTH);
  localparam bit SCLK_IDLE = (CPOL == CPOL_IDLE_HIGH) ? CPOL_IDLE_HIGH : CPOL_IDLE_LOW;

  // ---------------------------------------------------------------------------
  // Pin synchronisation and event decode
  // ---------------------------------------------------------------------------
  logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
  logic w_cs_sync, w_cs_rise, w_cs_fall;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic w_mosi_sync;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SCLK_IDLE)) u_sclk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (SCLK),
    .o_sync  (w_sclk_sync),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (CS),
    .o_sync  (w_cs_sync),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  // MOSI goes through the same depth as SCLK so data and clock stay aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_mosi_sync <= '0;
    else          r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
  end
  assign w_mosi_sync = r_mosi_sync[SYNC_STAGES-1];

  // A leading edge leaves the idle level, a trailing edge returns to it.
  logic w_sclk_edge, w_lead, w_trail, w_drive, w_sample;
  assign w_sclk_edge = w_sclk_rise | w_sclk_fall;
  assign w_lead      = w_sclk_edge & (w_sclk_sync != SCLK_IDLE);
  assign w_trail     = w_sclk_edge & (w_sclk_sync == SCLK_IDLE);
  assign w_sample    = (CPHA == CPHA_SAMPLE_LEADING) ? w_lead  : w_trail;
  assign w_drive     = (CPHA == CPHA_SAMPLE_LEADING) ? w_trail : w_lead;

  // ---------------------------------------------------------------------------
  // Datapath state
  // ---------------------------------------------------------------------------
  state_t                r_state;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_tx_word;
  logic [DATA_WIDTH-1:0] r_rx_shift;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_full;
  logic                  r_from_hold;      // current TX word came from holding
  logic                  r_reload_pending; // word boundary passed, reload on next drive
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_miso;
  logic                  r_miso_oe;
  logic                  r_underrun;
  logic                  r_abort;

  logic [CNT_W-1:0]      w_bit_idx;
  logic [CNT_W-1:0]      w_first_idx;
  logic [DATA_WIDTH-1:0] w_load_word;
  logic [DATA_WIDTH-1:0] w_rx_next;

  assign w_bit_idx   = CNT_W'(bit_index(32'(r_bit_cnt), LSB_FIRST, DATA_WIDTH));
  assign w_first_idx = CNT_W'(bit_index(32'd0, LSB_FIRST, DATA_WIDTH));
  // An empty holding register transmits zeros.
  assign w_load_word = r_hold_full ? r_hold : '0;

  always_comb begin
    w_rx_next            = r_rx_shift;
    w_rx_next[w_bit_idx] = w_mosi_sync;
  end

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= ST_IDLE;
      r_bit_cnt        <= '0;
      r_tx_word        <= '0;
      r_rx_shift       <= '0;
      r_hold           <= '0;
      r_hold_full      <= 1'b0;
      r_from_hold      <= 1'b0;
      r_reload_pending <= 1'b0;
      r_rx_data        <= '0;
      r_rx_valid       <= 1'b0;
      r_miso           <= 1'b0;
      r_miso_oe        <= 1'b0;
      r_underrun       <= 1'b0;
      r_abort          <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;

      // Clearing first so that a set event later in this block wins.
      if (clr_status) begin
        r_underrun <= 1'b0;
        r_abort    <= 1'b0;
      end

      // Writes while full are dropped; clearing only ever happens while full.
      if (tx_valid && !r_hold_full) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end

      if (w_cs_rise) begin
        r_state          <= ST_IDLE;
        r_miso           <= 1'b0;
        r_miso_oe        <= 1'b0;
        r_bit_cnt        <= '0;
        r_reload_pending <= 1'b0;
        if (r_bit_cnt != '0) r_abort <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_miso    <= 1'b0;
            r_miso_oe <= 1'b0;
            if (w_cs_fall) r_state <= ST_LOAD;
          end

          ST_LOAD: begin
            r_tx_word        <= w_load_word;
            r_from_hold      <= r_hold_full;
            r_bit_cnt        <= '0;
            r_reload_pending <= 1'b0;
            r_miso_oe        <= 1'b1;
            if (!r_hold_full) r_underrun <= 1'b1;
            // CPHA=0 has no leading drive edge, so the first bit goes out now.
            if (CPHA == CPHA_SAMPLE_LEADING) r_miso <= w_load_word[w_first_idx];
            r_state <= ST_SHIFT;
          end

          ST_SHIFT: begin
            if (w_drive) begin
              if (r_reload_pending) begin
                r_tx_word        <= w_load_word;
                r_from_hold      <= r_hold_full;
                r_reload_pending <= 1'b0;
                r_miso           <= w_load_word[w_first_idx];
                if (!r_hold_full) r_underrun <= 1'b1;
              end else begin
                r_miso <= r_tx_word[w_bit_idx];
              end
            end

            if (w_sample) begin
              r_rx_shift <= w_rx_next;
              // The word is consumed only once the master actually clocks it.
              if ((r_bit_cnt == '0) && r_from_hold) begin
                r_hold_full <= 1'b0;
                r_from_hold <= 1'b0;
              end
              if (r_bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                r_rx_data        <= w_rx_next;
                r_rx_valid       <= 1'b1;
                r_bit_cnt        <= '0;
                r_reload_pending <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              end
            end
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign MISO     = r_miso;
  assign MISO_oe  = r_miso_oe;
  assign tx_ready = ~r_hold_full;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = ~w_cs_sync;
  assign underrun = r_underrun;
  assign abort    = r_abort;

endmodule
